// File: rtl/operand_load_ctrl.sv
// Operand load sequencer: debounced load pulses capture the switch word into
// successive operand slots, then the full set is offered with a valid/ack handshake.
module operand_load_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N_SLOTS = 2,
  localparam int IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       load_deb,
  input  logic [DATA_W-1:0]          sw,
  input  logic                       ack,
  output logic [N_SLOTS*DATA_W-1:0]  operands,
  output logic [IDX_W-1:0]           slot_idx,
  output logic [N_SLOTS-1:0]         slot_led,
  output logic                       valid,
  output logic                       overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx_next;
  logic             overrun_next;
  logic             capture;
  logic             clear_all;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_next   = state;
    idx_next     = slot_idx;
    overrun_next = overrun;
    capture      = 1'b0;
    clear_all    = 1'b0;

    if (clr) begin
      // clr outranks any coincident load_deb or ack
      state_next   = S_IDLE;
      idx_next     = '0;
      overrun_next = 1'b0;
      clear_all    = 1'b1;
    end else begin
      unique case (state)
        S_IDLE, S_COLLECT: begin
          if (load_deb) begin
            capture = 1'b1;
            if (slot_idx == LAST_IDX) begin
              state_next = S_VALID;
              idx_next   = '0;
            end else begin
              state_next = S_COLLECT;
              idx_next   = slot_idx + 1'b1;
            end
          end
        end
        S_VALID: begin
          if (ack) begin
            state_next = S_IDLE;
          end else if (load_deb) begin
            overrun_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      slot_idx <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      slot_idx <= idx_next;
      overrun  <= overrun_next;
    end
  end

  // Operand bank keeps its contents across ack; only rst/clr zero it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operands <= '0;
    end else if (clear_all) begin
      operands <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        if (32'(slot_idx) == k) begin
          operands[k*DATA_W +: DATA_W] <= sw;
        end
      end
    end
  end

  assign valid = (state == S_VALID);

  always_comb begin
    slot_led = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      slot_led[k] = (state != S_VALID) && (32'(slot_idx) == k);
    end
  end

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Self-checking bench for operand_load_ctrl: directed scenarios plus random
// traffic on a two-slot and a one-slot instance, checked against a slot-count model.
module tb_operand_load_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        clr2, load2, ack2;
  logic [7:0]  sw2;
  logic [15:0] operands2;
  logic [0:0]  slot_idx2;
  logic [1:0]  slot_led2;
  logic        valid2, overrun2;

  logic        clr1, load1, ack1;
  logic [7:0]  sw1;
  logic [7:0]  operands1;
  logic [0:0]  slot_idx1;
  logic [0:0]  slot_led1;
  logic        valid1, overrun1;

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, how many words are held so far,
  // whether the set is complete, the captured words and the overrun flag.
  int         m_cnt  [2];
  bit         m_full [2];
  bit         m_ovr  [2];
  logic [7:0] m_ops  [2][2];

  operand_load_ctrl #(.DATA_W(8), .N_SLOTS(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .load_deb(load2), .sw(sw2), .ack(ack2),
    .operands(operands2), .slot_idx(slot_idx2), .slot_led(slot_led2),
    .valid(valid2), .overrun(overrun2)
  );

  operand_load_ctrl #(.DATA_W(8), .N_SLOTS(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .load_deb(load1), .sw(sw1), .ack(ack1),
    .operands(operands1), .slot_idx(slot_idx1), .slot_led(slot_led1),
    .valid(valid1), .overrun(overrun1)
  );

  always #5 clk = ~clk;

  function automatic int n_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic model_reset(int d);
    m_cnt[d]  = 0;
    m_full[d] = 1'b0;
    m_ovr[d]  = 1'b0;
    for (int k = 0; k < 2; k++) m_ops[d][k] = 8'h00;
  endtask

  task automatic model_step(int d, bit c, bit l, logic [7:0] s, bit a);
    if (c) begin
      model_reset(d);
    end else if (m_full[d]) begin
      if (a)      m_full[d] = 1'b0;
      else if (l) m_ovr[d]  = 1'b1;
    end else if (l) begin
      m_ops[d][m_cnt[d]] = s;
      m_cnt[d]++;
      if (m_cnt[d] == n_of(d)) begin
        m_full[d] = 1'b1;
        m_cnt[d]  = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(int d);
    logic [31:0] e_ops;
    logic [31:0] e_led;
    e_ops = '0;
    for (int k = 0; k < n_of(d); k++) e_ops[k*8 +: 8] = m_ops[d][k];
    e_led = m_full[d] ? 32'd0 : (32'd1 << m_cnt[d]);
    if (d == 0) begin
      check("d2.operands", 32'(operands2), e_ops);
      check("d2.slot_idx", 32'(slot_idx2), 32'(m_cnt[d]));
      check("d2.slot_led", 32'(slot_led2), e_led);
      check("d2.valid",    32'(valid2),    32'(m_full[d]));
      check("d2.overrun",  32'(overrun2),  32'(m_ovr[d]));
    end else begin
      check("d1.operands", 32'(operands1), e_ops);
      check("d1.slot_idx", 32'(slot_idx1), 32'(m_cnt[d]));
      check("d1.slot_led", 32'(slot_led1), e_led);
      check("d1.valid",    32'(valid1),    32'(m_full[d]));
      check("d1.overrun",  32'(overrun1),  32'(m_ovr[d]));
    end
  endtask

  // One clock: inputs already driven are applied at the edge, outputs are
  // sampled 1 time unit later, then the single-cycle inputs drop back to 0.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0, clr2, load2, sw2, ack2);
    model_step(1, clr1, load1, sw1, ack1);
    check_all(0);
    check_all(1);
    clr2 = 1'b0; load2 = 1'b0; ack2 = 1'b0;
    clr1 = 1'b0; load1 = 1'b0; ack1 = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    clr2 = 1'b0; load2 = 1'b0; ack2 = 1'b0; sw2 = 8'h00;
    clr1 = 1'b0; load1 = 1'b0; ack1 = 1'b0; sw1 = 8'h00;
    #1;
    model_reset(0);
    model_reset(1);
    check_all(0);
    check_all(1);
    #3 rst = 1'b0;

    // Async reset in the middle of a collection
    sw2 = 8'h5A; load2 = 1'b1; tick();
    check("t1.slot_idx_before", 32'(slot_idx2), 32'd1);
    #1 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check_all(0);
    check_all(1);
    check("t1.slot_led", 32'(slot_led2), 32'd1);
    rst = 1'b0;

    // Two captures complete the set
    sw2 = 8'h3C; load2 = 1'b1; tick();
    check("t2.valid_mid", 32'(valid2), 32'd0);
    sw2 = 8'hA5; load2 = 1'b1; tick();
    check("t2.operands", 32'(operands2), 32'h0000A53C);
    check("t2.valid",    32'(valid2),    32'd1);
    check("t2.slot_led", 32'(slot_led2), 32'd0);

    // Load while valid is dropped and flagged; ack returns to idle
    sw2 = 8'hFF; load2 = 1'b1; tick();
    check("t3.operands", 32'(operands2), 32'h0000A53C);
    check("t3.overrun",  32'(overrun2),  32'd1);
    ack2 = 1'b1; tick();
    check("t3.valid_after_ack",   32'(valid2),   32'd0);
    check("t3.overrun_after_ack", 32'(overrun2), 32'd1);
    check("t3.operands_retained", 32'(operands2), 32'h0000A53C);
    tick();
    check("t3.ack_outside_valid", 32'(overrun2), 32'd1);
    clr2 = 1'b1; tick();

    // Load with ack in the same cycle: ack wins, no overrun
    sw2 = 8'h12; load2 = 1'b1; tick();
    sw2 = 8'h34; load2 = 1'b1; tick();
    sw2 = 8'h99; load2 = 1'b1; ack2 = 1'b1; tick();
    check("t4.valid",    32'(valid2),    32'd0);
    check("t4.overrun",  32'(overrun2),  32'd0);
    check("t4.operands", 32'(operands2), 32'h00003412);
    check("t4.slot_idx", 32'(slot_idx2), 32'd0);

    // clr beats a coincident load in idle
    clr2 = 1'b1; tick();
    sw2 = 8'h11; load2 = 1'b1; clr2 = 1'b1; tick();
    check("t5.operands", 32'(operands2), 32'd0);
    check("t5.slot_idx", 32'(slot_idx2), 32'd0);

    // Single-slot instance goes straight to valid
    sw1 = 8'h7E; load1 = 1'b1; tick();
    check("t6.valid",    32'(valid1),    32'd1);
    check("t6.operands", 32'(operands1), 32'h7E);
    ack1 = 1'b1; tick();

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      clr2  = ($urandom_range(0, 39) == 0);
      load2 = ($urandom_range(0, 99) < 45);
      ack2  = ($urandom_range(0, 99) < 30);
      sw2   = 8'($urandom);
      clr1  = ($urandom_range(0, 39) == 0);
      load1 = ($urandom_range(0, 99) < 45);
      ack1  = ($urandom_range(0, 99) < 30);
      sw1   = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
